// File: rtl/ascii_operand_parser_pkg.sv
// Shared definitions for the ASCII operand parser: character codes, FSM state
// encodings and the character-class record.
package ascii_operand_parser_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;
   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_EQ    = 8'h3D;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam logic [1:0] ST_GET_A = 2'd0;
   localparam logic [1:0] ST_GET_B = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   typedef struct packed {
      logic       is_digit;
      logic       is_plus;
      logic       is_eq;
      logic       is_space;
      logic [3:0] bcd;
   } char_class_t;

endpackage

// File: rtl/ascii_operand_parser_char_class.sv
// Combinational decoder classifying one ASCII character for the operand parser.
module ascii_char_class
   import ascii_operand_parser_pkg::*;
(
   input  logic [7:0] in_char_i,
   output logic       is_digit_o,
   output logic       is_plus_o,
   output logic       is_eq_o,
   output logic       is_space_o,
   output logic [3:0] bcd_o
);

   assign is_digit_o = (in_char_i >= ASCII_ZERO) && (in_char_i <= ASCII_NINE);
   assign is_plus_o  = (in_char_i == ASCII_PLUS);
   assign is_eq_o    = (in_char_i == ASCII_EQ);
   assign is_space_o = (in_char_i == ASCII_SPACE);
   // '0'..'9' are 0x30..0x39, so the low nibble already equals char - 0x30
   assign bcd_o      = in_char_i[3:0];

endmodule

// File: rtl/ascii_operand_parser.sv
// ASCII "<digits>+<digits>=" parser packing two BCD operands behind a valid/ready
// handshake. Optional build macro: ASCII_PARSER_SPACE_SKIP_EN (ignore spaces).
module ascii_operand_parser
   import ascii_operand_parser_pkg::*;
#(
   parameter int unsigned DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_char,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [4*DIGITS-1:0]   op_a,
   output logic [4*DIGITS-1:0]   op_b,
   output logic                  err
);

   localparam int unsigned W     = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(DIGITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIGITS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [W-1:0]     op_a_q, op_a_d;
   logic [W-1:0]     op_b_q, op_b_d;
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
   logic             err_q, err_d;

   char_class_t cls;
   logic        take;
   logic        bad;

   ascii_char_class u_char_class (
      .in_char_i  (in_char),
      .is_digit_o (cls.is_digit),
      .is_plus_o  (cls.is_plus),
      .is_eq_o    (cls.is_eq),
      .is_space_o (cls.is_space),
      .bcd_o      (cls.bcd)
   );

   assign in_ready = (state_q != ST_HOLD);
   assign op_valid = (state_q == ST_HOLD);
   assign err      = err_q;
   assign op_a     = op_a_q;
   assign op_b     = op_b_q;
   assign take     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      err_d   = 1'b0;
      bad     = 1'b0;

      if (state_q == ST_HOLD) begin
         if (op_ready) begin
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = ST_GET_A;
         end
      end else if (take) begin
         case (state_q)
            ST_GET_A: begin
               if (cls.is_digit) begin
                  if (cnt_a_q == CNT_MAX) begin
                     bad = 1'b1;
                  end else begin
                     op_a_d  = {op_a_q[W-5:0], cls.bcd};
                     cnt_a_d = cnt_a_q + CNT_ONE;
                  end
               end else if (cls.is_plus && (cnt_a_q != '0)) begin
                  state_d = ST_GET_B;
`ifdef ASCII_PARSER_SPACE_SKIP_EN
               end else if (cls.is_space) begin
                  state_d = ST_GET_A;
`endif
               end else begin
                  bad = 1'b1;
               end
            end
            ST_GET_B: begin
               if (cls.is_digit) begin
                  if (cnt_b_q == CNT_MAX) begin
                     bad = 1'b1;
                  end else begin
                     op_b_d  = {op_b_q[W-5:0], cls.bcd};
                     cnt_b_d = cnt_b_q + CNT_ONE;
                  end
               end else if (cls.is_eq && (cnt_b_q != '0)) begin
                  state_d = ST_HOLD;
`ifdef ASCII_PARSER_SPACE_SKIP_EN
               end else if (cls.is_space) begin
                  state_d = ST_GET_B;
`endif
               end else begin
                  bad = 1'b1;
               end
            end
            default: state_d = ST_GET_A;
         endcase

         if (bad) begin
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            state_d = ST_GET_A;
            err_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_GET_A;
         op_a_q  <= '0;
         op_b_q  <= '0;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         err_q   <= err_d;
      end
   end

endmodule
